fwd_hazard_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the EXE stage of the 5-stage pipeline. It tracks destination registers of in-flight instructions and produces registered `a_ctrl`/`b_ctrl` selects for the EXE operand muxes: register value, shift amount/immediate, EXE/MEM forward or MEM/WB forward. It also raises `stall` to hold IF/ID and insert a bubble on a load-use hazard, and counts stall cycles for performance monitoring.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/fwd_sel.sv | 34 +++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 5-stage pipeline control logic.
//   - REG_W        : register-number width
//   - sel_t        : 2-bit EXE operand-mux select, with its four encodings
//   - dst_t        : destination record of an in-flight instruction {wreg, rn}
//   - trk_t        : EXE-slot tracking record, i.e. destination plus load flag
//   - dst_hit()    : forwarding match test of one source against one producer
package pipe_pkg;

  localparam int REG_W = 5;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_REG = 2'b00;  // register-file operand
  localparam sel_t SEL_ALT = 2'b01;  // shift amount (A) or immediate (B)
  localparam sel_t SEL_EXE = 2'b10;  // forward from EXE/MEM
  localparam sel_t SEL_MEM = 2'b11;  // forward from MEM/WB

  typedef struct packed {
    logic             wreg;
    logic [REG_W-1:0] rn;
  } dst_t;

  typedef struct packed {
    dst_t dst;
    logic m2reg;
  } trk_t;

  // A source depends on a producer only if it is actually read, is not r0,
  // and the producer writes that same register.
  function automatic logic dst_hit(input logic             use_src,
                                   input logic [REG_W-1:0] src,
                                   input dst_t             prod);
    return use_src && (src != '0) && prod.wreg && (prod.rn == src);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: combinational priority comparator for one EXE operand mux.
// Ports:
//   use_src  in  source is read by the ID instruction
//   src      in  source register number
//   alt      in  operand takes its alternate input (shamt / immediate)
//   ex       in  destination of the instruction one stage ahead
//   mem      in  destination of the instruction two stages ahead
//   sel      out operand select (SEL_ALT > SEL_EXE > SEL_MEM > SEL_REG)
module fwd_sel
  import pipe_pkg::*;
(
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  logic             alt,
  input  dst_t             ex,
  input  dst_t             mem,
  output sel_t             sel
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    sel = SEL_REG;
    if (alt) begin
      sel = SEL_ALT;
    end else if (dst_hit(use_src, src, ex)) begin
      // The nearer producer holds the newest value of the register.
      sel = SEL_EXE;
    end else if (dst_hit(use_src, src, mem)) begin
      sel = SEL_MEM;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and load-use hazard controller for the EXE stage.
// Tracks the destinations of the two instructions ahead of ID and produces the
// registered EXE operand-mux selects, a combinational load-use stall, and a
// saturating stall-cycle counter.
// Ports:
//   clk        in   pipeline clock
//   clrn       in   synchronous active-low reset
//   id_rs/rt   in   ID source registers A/B
//   id_use_rs  in   ID instruction reads rs
//   id_use_rt  in   ID instruction reads rt (ALU operand or store data)
//   id_shift   in   ALU A takes the shift amount
//   id_aluimm  in   ALU B takes the immediate
//   id_wreg    in   ID instruction writes the register file
//   id_rn      in   ID destination register
//   id_m2reg   in   ID instruction is a load
//   id_cancel  in   ID instruction is dead (treated as a bubble)
//   stall      out  hold PC and IF/ID, bubble into ID/EXE (combinational)
//   a_ctrl     out  registered ALU A select
//   b_ctrl     out  registered ALU B select
//   st_ctrl    out  registered store-data select
//   stall_cnt  out  saturating count of stall cycles
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_shift,
  input  logic             id_aluimm,
  input  logic             id_wreg,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_m2reg,
  input  logic             id_cancel,
  output logic             stall,
  output sel_t             a_ctrl,
  output sel_t             b_ctrl,
  output sel_t             st_ctrl,
  output logic [CNT_W-1:0] stall_cnt
);

  // Instruction one stage ahead (in EXE) and two stages ahead (in MEM).
  // Once a load reaches MEM its data is forwardable, so the MEM slot does not
  // need to remember whether its producer was a load.
  trk_t ex_q;
  dst_t mem_q;

  sel_t sel_a;
  sel_t sel_b;
  sel_t sel_st;
  logic bubble;

  // A shift reads the shift amount instead of rs, so rs cannot cause a stall.
  assign stall = !id_cancel && ex_q.m2reg &&
                 (dst_hit(id_use_rs && !id_shift, id_rs, ex_q.dst) ||
                  dst_hit(id_use_rt, id_rt, ex_q.dst));

  // A stalled or cancelled ID instruction does not advance; EXE gets a bubble.
  assign bubble = stall || id_cancel;

  fwd_sel u_sel_a (
    .use_src (id_use_rs),
    .src     (id_rs),
    .alt     (id_shift),
    .ex      (ex_q.dst),
    .mem     (mem_q),
    .sel     (sel_a)
  );

  fwd_sel u_sel_b (
    .use_src (id_use_rt),
    .src     (id_rt),
    .alt     (id_aluimm),
    .ex      (ex_q.dst),
    .mem     (mem_q),
    .sel     (sel_b)
  );

  // Store data always comes from rt, even when ALU B takes the immediate.
  fwd_sel u_sel_st (
    .use_src (id_use_rt),
    .src     (id_rt),
    .alt     (1'b0),
    .ex      (ex_q.dst),
    .mem     (mem_q),
    .sel     (sel_st)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others (mem_q takes the old ex_q).
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ex_q      <= '0;
      mem_q     <= '0;
      a_ctrl    <= SEL_REG;
      b_ctrl    <= SEL_REG;
      st_ctrl   <= SEL_REG;
      stall_cnt <= '0;
    end else begin
      mem_q         <= ex_q.dst;
      ex_q.dst.wreg <= id_wreg && !bubble;
      ex_q.dst.rn   <= id_rn;
      ex_q.m2reg    <= id_m2reg;
      a_ctrl        <= bubble ? SEL_REG : sel_a;
      b_ctrl        <= bubble ? SEL_REG : sel_b;
      st_ctrl       <= bubble ? SEL_REG : sel_st;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios with literal expectations followed by
// randomized instruction streams, all compared every cycle against a
// behavioural model kept as a short history of issued instructions.
module tb_fwd_hazard_ctrl;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [4:0]       id_rs = '0, id_rt = '0, id_rn = '0;
  logic             id_use_rs = 0, id_use_rt = 0, id_shift = 0, id_aluimm = 0;
  logic             id_wreg = 0, id_m2reg = 0, id_cancel = 0;
  logic             stall;
  logic [1:0]       a_ctrl, b_ctrl, st_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_shift  (id_shift),
    .id_aluimm (id_aluimm),
    .id_wreg   (id_wreg),
    .id_rn     (id_rn),
    .id_m2reg  (id_m2reg),
    .id_cancel (id_cancel),
    .stall     (stall),
    .a_ctrl    (a_ctrl),
    .b_ctrl    (b_ctrl),
    .st_ctrl   (st_ctrl),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the instruction one stage ahead of ID, hist[1] two stages ahead.
  typedef struct {
    bit wr;
    int rn;
    bit ld;
  } prod_t;

  prod_t hist[2];
  bit    m_valid = 0;
  logic [1:0] e_a, e_b, e_st;
  int    e_cnt;

  // Distance (1 or 2) of the nearest in-flight writer of src, 0 if none.
  function automatic int producer_dist(input bit rd, input int src);
    if (!rd || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].wr && hist[k].rn == src) return k + 1;
    return 0;
  endfunction

  function automatic logic [1:0] dist_sel(input int d);
    case (d)
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Load-use: the instruction right ahead is a load that writes what ID needs
  // as a register operand right now.
  function automatic bit model_stall();
    bit need_a, need_b;
    need_a = id_use_rs && !id_shift && producer_dist(id_use_rs, int'(id_rs)) == 1;
    need_b = producer_dist(id_use_rt, int'(id_rt)) == 1;
    return !id_cancel && hist[0].ld && (need_a || need_b);
  endfunction

  // Single compare process: outputs checked away from the rising edge, then
  // the model advances to what the coming edge will produce.
  always @(negedge clk) begin
    bit s;
    s = model_stall();
    if (m_valid) begin
      check("stall",     stall,     s);
      check("a_ctrl",    a_ctrl,    e_a);
      check("b_ctrl",    b_ctrl,    e_b);
      check("st_ctrl",   st_ctrl,   e_st);
      check("stall_cnt", stall_cnt, e_cnt);
    end
    if (!clrn) begin
      hist[0] = '{0, 0, 0};
      hist[1] = '{0, 0, 0};
      e_a = 0; e_b = 0; e_st = 0; e_cnt = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (s || id_cancel) begin
        e_a = 2'b00; e_b = 2'b00; e_st = 2'b00;
      end else begin
        e_a  = id_shift  ? 2'b01 : dist_sel(producer_dist(id_use_rs, int'(id_rs)));
        e_b  = id_aluimm ? 2'b01 : dist_sel(producer_dist(id_use_rt, int'(id_rt)));
        e_st = dist_sel(producer_dist(id_use_rt, int'(id_rt)));
      end
      if (s && e_cnt < int'(CNT_MAX)) e_cnt++;
      hist[1] = hist[0];
      hist[0] = '{id_wreg && !s && !id_cancel, int'(id_rn), id_m2reg};
    end
  end

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                       input bit sh, input bit imm, input bit wr, input int rn,
                       input bit ld, output bit st);
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_shift = sh; id_aluimm = imm; id_wreg = wr; id_rn = 5'(rn);
    id_m2reg = ld; id_cancel = 0;
    #3 st = stall;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clrn = 0;
    @(posedge clk); #1;
    clrn = 1;
  endtask

  // Watchdog: the bench never waits on a DUT event, but bound the run anyway.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit st;
    @(posedge clk); #1;
    do_reset();
    check("rst_a", a_ctrl, 2'b00);
    check("rst_cnt", stall_cnt, 0);

    // add r3,r1,r2 ; sub r4,r3,r5
    issue(1, 2, 1, 1, 0, 0, 1, 3, 0, st);
    issue(3, 5, 1, 1, 0, 0, 1, 4, 0, st);
    check("t1_stall", st, 0);
    check("t1_a", a_ctrl, 2'b10);
    check("t1_b", b_ctrl, 2'b00);

    // add r3 ; unrelated ; or r6,r7,r3
    do_reset();
    issue(1, 2, 1, 1, 0, 0, 1, 3, 0, st);
    issue(9, 10, 1, 1, 0, 0, 1, 8, 0, st);
    issue(7, 3, 1, 1, 0, 0, 1, 6, 0, st);
    check("t2_a", a_ctrl, 2'b00);
    check("t2_b", b_ctrl, 2'b11);

    // lw r3,0(r1) ; add r4,r3,r3 (stalls once, then forwards from MEM)
    do_reset();
    issue(1, 0, 1, 0, 0, 1, 1, 3, 1, st);
    issue(3, 3, 1, 1, 0, 0, 1, 4, 0, st);
    check("t3_stall", st, 1);
    check("t3_bub_a", a_ctrl, 2'b00);
    check("t3_bub_b", b_ctrl, 2'b00);
    issue(3, 3, 1, 1, 0, 0, 1, 4, 0, st);
    check("t3_nostall", st, 0);
    check("t3_a", a_ctrl, 2'b11);
    check("t3_b", b_ctrl, 2'b11);
    check("t3_cnt", stall_cnt, 1);

    // add r3 ; sll r2,r3,4 (rs field = r3, A takes shamt)
    do_reset();
    issue(1, 2, 1, 1, 0, 0, 1, 3, 0, st);
    issue(3, 3, 1, 1, 1, 0, 1, 2, 0, st);
    check("t4_a", a_ctrl, 2'b01);
    check("t4_b", b_ctrl, 2'b10);
    // lw r3 ; shift whose rs is r3 and rt is r5: no stall through A
    issue(1, 0, 1, 0, 0, 1, 1, 3, 1, st);
    issue(3, 5, 1, 1, 1, 0, 1, 2, 0, st);
    check("t4_shift_stall", st, 0);

    // r0 never forwards or stalls
    do_reset();
    issue(1, 2, 1, 1, 0, 0, 1, 0, 0, st);
    issue(0, 0, 1, 1, 0, 0, 1, 4, 0, st);
    check("t5_r0_a", a_ctrl, 2'b00);
    check("t5_r0_b", b_ctrl, 2'b00);
    issue(1, 0, 1, 0, 0, 1, 1, 0, 1, st);
    issue(0, 0, 1, 1, 0, 0, 1, 4, 0, st);
    check("t5_r0_stall", st, 0);
    // two writers of r3: nearest wins
    issue(1, 2, 1, 1, 0, 0, 1, 3, 0, st);
    issue(4, 5, 1, 1, 0, 0, 1, 3, 0, st);
    issue(3, 6, 1, 1, 0, 0, 1, 7, 0, st);
    check("t5_near_a", a_ctrl, 2'b10);

    // reset in the middle of a stall
    do_reset();
    issue(1, 0, 1, 0, 0, 1, 1, 3, 1, st);
    id_rs = 3; id_rt = 3; id_use_rs = 1; id_use_rt = 1; id_shift = 0;
    id_aluimm = 0; id_wreg = 1; id_rn = 4; id_m2reg = 0; clrn = 0;
    #3 check("t6_pre_stall", stall, 1);
    @(posedge clk); #1;
    clrn = 1;
    check("t6_stall", stall, 0);
    check("t6_a", a_ctrl, 2'b00);
    check("t6_cnt", stall_cnt, 0);

    // saturation: lw r3,0(r3) repeated, each pair yields one stall
    do_reset();
    for (int i = 0; i < int'(CNT_MAX) + 10; i++) begin
      issue(3, 0, 1, 0, 0, 1, 1, 3, 1, st);
      issue(3, 0, 1, 0, 0, 1, 1, 3, 1, st);
    end
    check("t7_sat", stall_cnt, CNT_MAX);

    // randomized stream; a stalled instruction is re-presented as-is
    do_reset();
    st = 0;
    for (int i = 0; i < 4000; i++) begin
      clrn = ($urandom_range(0, 99) != 0);
      if (!st) begin
        id_rs     = 5'($urandom_range(0, 4));
        id_rt     = 5'($urandom_range(0, 4));
        id_rn     = 5'($urandom_range(0, 4));
        id_use_rs = 1'($urandom_range(0, 3) != 0);
        id_use_rt = 1'($urandom_range(0, 3) != 0);
        id_shift  = 1'($urandom_range(0, 5) == 0);
        id_aluimm = 1'($urandom_range(0, 3) == 0);
        id_wreg   = 1'($urandom_range(0, 4) != 0);
        id_m2reg  = 1'($urandom_range(0, 2) == 0);
        id_cancel = 1'($urandom_range(0, 9) == 0);
      end
      #3 st = model_stall() && clrn;
      @(posedge clk); #1;
    end
    clrn = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
